// File: rtl/rr_grant_ctrl4_pkg.sv
// Shared constants and types for the 4-way round-robin grant controller.
// Holds requester count, index/counter widths and the FSM state encoding.
package rr_grant_ctrl4_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;
  localparam int CNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  typedef logic [N_REQ-1:0] req_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_SAT = '1;

endpackage

// File: rtl/rr_grant_ctrl4_gnt_decoder.sv
// 2-to-4 one-hot decoder for the grant vector, purely combinational.
// Ports: idx (binary index in), onehot (decoded one-hot out).
module gnt_decoder
  import rr_grant_ctrl4_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_grant_ctrl4.sv
// Four-requester round-robin arbiter with per-tenure hold-time limit.
// Ports: clk, rst_n (async low), req[3:0] in; gnt, gnt_idx, gnt_valid, timeout out.
module rr_grant_ctrl4
  import rr_grant_ctrl4_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam cnt_t HOLD_CNT = CNT_W'(HOLD_MAX);
  localparam bit   LIM_EN   = (HOLD_MAX != 0);

  state_e state_q, state_d;
  idx_t   idx_q, idx_d;
  idx_t   ptr_q, ptr_d;
  cnt_t   cnt_q, cnt_d;
  req_t   gnt_q, gnt_d;
  logic   to_q, to_d;

  idx_t   win_idx;
  logic   win_found;
  req_t   dec;

  // Search ptr+1, ptr+2, ptr+3, ptr (mod 4); first set bit wins.
  always_comb begin
    idx_t cand;
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ptr_q + IDX_W'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        idx_d = '0;
        cnt_d = '0;
        if (win_found) begin
          state_d = GRANT;
          idx_d   = win_idx;
          cnt_d   = cnt_t'(1);
        end
      end
      GRANT: begin
        // Release has priority over the hold limit.
        if (!req[idx_q]) begin
          state_d = IDLE;
          ptr_d   = idx_q;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (LIM_EN && cnt_q == HOLD_CNT) begin
          state_d = IDLE;
          ptr_d   = idx_q;
          idx_d   = '0;
          cnt_d   = '0;
          to_d    = 1'b1;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  gnt_decoder u_dec (
    .idx    (idx_d),
    .onehot (dec)
  );

  assign gnt_d = (state_d == GRANT) ? dec : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= idx_t'(N_REQ - 1);
      cnt_q   <= '0;
      gnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      to_q    <= to_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = (state_q == GRANT);
  assign timeout   = to_q;

endmodule
